// File: rtl/ram_pkg.sv
// Shared types and constants for the parametrised scratch RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a. RD_LAT follows the RAM_OUT_REG_EN macro.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int RAM_DATA_W = 16;
    localparam int RAM_BYTE_W = 8;
    localparam int NUM_BE     = RAM_DATA_W / RAM_BYTE_W;

`ifdef RAM_OUT_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    // Number of byte lanes for a given word and lane width.
    function automatic int lanes(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Post-reset clear sequencer: walks addresses 0..DEPTH-1 issuing zero writes.
// Latency: exactly DEPTH cycles from reset release until busy falls.
// Backpressure: none; busy is the only status and the sequence never stalls.
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    // State and counter registers; reset restarts the clear from address 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // One zero write per cycle; leave ST_CLEAR on the edge that writes the last word.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        clr_we    = 1'b0;
        clr_addr  = cnt;
        case (state)
            ST_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = ST_READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_READY: begin
                state_nxt = ST_READY;
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

endmodule

// File: rtl/param_ram.sv
// Single-port scratch RAM with byte-lane writes, read-valid strobe and hardware clear after reset.
// Latency: read data 1 cycle after RD (2 cycles when RAM_OUT_REG_EN is defined); ERR always 1 cycle.
// Backpressure: none; requests while BUSY, RD+WR together or out-of-range addresses are flagged on ERR.
module param_ram
    import ram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1 << ADDR_W,
    parameter int BYTE_W = 8
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       WR,
    input  logic                       RD,
    input  logic [ADDR_W-1:0]          ADDR,
    input  logic [DATA_W-1:0]          IN,
    input  logic [DATA_W/BYTE_W-1:0]   BE,
    output logic [DATA_W-1:0]          OUT,
    output logic                       OUT_VALID,
    output logic                       BUSY,
    output logic                       ERR
);

    localparam int              NBE     = lanes(DATA_W, BYTE_W);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              addr_ok;
    logic              wr_ok;
    logic              rd_go;
    logic              err_nxt;

    logic [DATA_W-1:0] out_q;
    logic              vld_q;
    logic              err_q;

    ram_clear_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Request decode: accept lone RD or WR only when idle; everything else is an error.
    always_comb begin
        addr_ok = ({1'b0, ADDR} < DEPTH_L);
        wr_ok   = !busy && WR && !RD && addr_ok;
        rd_go   = !busy && RD && !WR;
        err_nxt = (busy && (RD || WR))
               || (!busy && RD && WR)
               || (!busy && (RD ^ WR) && !addr_ok);
    end

    // Array write port: clear sequencer owns it while busy, else masked user writes.
    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NBE; i++) begin
                if (BE[i]) begin
                    mem[ADDR][i*BYTE_W +: BYTE_W] <= IN[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // First read stage and error strobe; data holds until the next completed read.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_q <= '0;
            vld_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            vld_q <= rd_go;
            err_q <= err_nxt;
            if (rd_go) begin
                out_q <= addr_ok ? mem[ADDR] : '0;
            end
        end
    end

`ifdef RAM_OUT_REG_EN
    logic [DATA_W-1:0] out_q2;
    logic              vld_q2;

    // Optional output pipeline stage; an in-flight read is dropped on reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_q2 <= '0;
            vld_q2 <= 1'b0;
        end else begin
            vld_q2 <= vld_q;
            if (vld_q) begin
                out_q2 <= out_q;
            end
        end
    end

    assign OUT       = out_q2;
    assign OUT_VALID = vld_q2;
`else
    assign OUT       = out_q;
    assign OUT_VALID = vld_q;
`endif

    assign BUSY = busy;
    assign ERR  = err_q;

endmodule

// File: tb/tb_param_ram.sv
// Directed self-checking bench for param_ram (DEPTH below 2**ADDR_W to reach the out-of-range path).
// Latency: expectations follow ram_pkg::RD_LAT.
// Backpressure: n/a.
module tb_param_ram;
    import ram_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1000;
    localparam int BYTE_W = 8;
    localparam int LAT    = RD_LAT;

    logic                     CLK;
    logic                     RST_N;
    logic                     WR;
    logic                     RD;
    logic [ADDR_W-1:0]        ADDR;
    logic [DATA_W-1:0]        IN;
    logic [DATA_W/BYTE_W-1:0] BE;
    logic [DATA_W-1:0]        OUT;
    logic                     OUT_VALID;
    logic                     BUSY;
    logic                     ERR;

    int errors = 0;
    int checks = 0;

    param_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BYTE_W (BYTE_W)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .WR        (WR),
        .RD        (RD),
        .ADDR      (ADDR),
        .IN        (IN),
        .BE        (BE),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic [1:0] be, output logic err);
        WR = 1'b1; ADDR = a; IN = d; BE = be;
        step();
        WR = 1'b0;
        err = ERR;
    endtask

    task automatic read_word(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                             output logic vld, output logic err);
        RD = 1'b1; ADDR = a;
        step();
        RD = 1'b0;
        err = ERR;
        repeat (LAT - 1) step();
        d = OUT;
        vld = OUT_VALID;
    endtask

    // Steps until BUSY drops (bounded); reports cycles taken and stray OUT_VALIDs seen.
    task automatic wait_clear(output int cycles, output int vlds);
        cycles = 0;
        vlds = 0;
        for (int i = 0; i < DEPTH + 20; i++) begin
            step();
            cycles++;
            if (OUT_VALID) vlds++;
            if (!BUSY) break;
        end
    endtask

    task automatic test_reset();
        int cyc, vl, bad, first_bad;
        logic [DATA_W-1:0] bad_val;
        #3 RST_N = 1'b0;
        #1;
        checks++;
        if (OUT !== '0 || OUT_VALID !== 1'b0 || BUSY !== 1'b1 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: OUT=%h OUT_VALID=%b BUSY=%b ERR=%b expected 0000 0 1 0",
                     OUT, OUT_VALID, BUSY, ERR);
        end
        step(); step();
        RST_N = 1'b1;
        wait_clear(cyc, vl);
        checks++;
        if (cyc !== DEPTH) begin
            errors++;
            $display("FAIL clear_length: BUSY high for %0d cycles, expected %0d", cyc, DEPTH);
        end
        // Read every address back to back; each must return 0 with OUT_VALID.
        bad = 0; first_bad = -1; bad_val = '0;
        for (int i = 0; i < DEPTH + LAT; i++) begin
            RD = (i < DEPTH);
            ADDR = (i < DEPTH) ? ADDR_W'(i) : '0;
            step();
            if (i >= LAT - 1 && i - (LAT - 1) < DEPTH) begin
                if (OUT_VALID !== 1'b1 || OUT !== '0) begin
                    if (bad == 0) begin first_bad = i - (LAT - 1); bad_val = OUT; end
                    bad++;
                end
            end
        end
        RD = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_readback: %0d bad reads, first addr %0d OUT=%h expected 0000 valid",
                     bad, first_bad, bad_val);
        end
    endtask

    task automatic test_write_read();
        logic e, v;
        logic [DATA_W-1:0] d;
        write_word(10'd5, 16'hABCD, 2'b11, e);
        checks++;
        if (e !== 1'b0 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL wr_full_status: ERR=%b OUT_VALID=%b expected 0 0", e, OUT_VALID);
        end
        read_word(10'd5, d, v, e);
        checks++;
        if (d !== 16'hABCD || v !== 1'b1 || e !== 1'b0) begin
            errors++;
            $display("FAIL rd_full: OUT=%h valid=%b err=%b expected abcd 1 0", d, v, e);
        end
        step();
        checks++;
        if (OUT_VALID !== 1'b0 || OUT !== 16'hABCD) begin
            errors++;
            $display("FAIL out_hold: OUT=%h OUT_VALID=%b expected abcd 0", OUT, OUT_VALID);
        end
    endtask

    task automatic test_byte_lanes();
        logic e, v;
        logic [DATA_W-1:0] d;
        write_word(10'd5, 16'h1234, 2'b01, e);
        read_word(10'd5, d, v, e);
        checks++;
        if (d !== 16'hAB34 || v !== 1'b1) begin
            errors++;
            $display("FAIL be_low_lane: OUT=%h valid=%b expected ab34 1", d, v);
        end
        write_word(10'd5, 16'h0000, 2'b00, e);
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_err: ERR=%b expected 0", e);
        end
        read_word(10'd5, d, v, e);
        checks++;
        if (d !== 16'hAB34) begin
            errors++;
            $display("FAIL be_zero_noop: OUT=%h expected ab34", d);
        end
    endtask

    task automatic test_collision();
        logic e, v;
        logic [DATA_W-1:0] d;
        RD = 1'b1; WR = 1'b1; ADDR = 10'd5; IN = 16'h0000; BE = 2'b11;
        step();
        RD = 1'b0; WR = 1'b0;
        checks++;
        if (ERR !== 1'b1 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL collide_err: ERR=%b OUT_VALID=%b expected 1 0", ERR, OUT_VALID);
        end
        step();
        checks++;
        if (ERR !== 1'b0 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL collide_pulse: ERR=%b OUT_VALID=%b expected 0 0", ERR, OUT_VALID);
        end
        read_word(10'd5, d, v, e);
        checks++;
        if (d !== 16'hAB34 || v !== 1'b1) begin
            errors++;
            $display("FAIL collide_nowrite: OUT=%h valid=%b expected ab34 1", d, v);
        end
    endtask

    task automatic test_out_of_range();
        logic e, v;
        logic [DATA_W-1:0] d;
        write_word(10'd999, 16'h9999, 2'b11, e);
        read_word(10'd999, d, v, e);
        checks++;
        if (d !== 16'h9999 || v !== 1'b1 || e !== 1'b0) begin
            errors++;
            $display("FAIL last_addr: OUT=%h valid=%b err=%b expected 9999 1 0", d, v, e);
        end
        write_word(10'd1010, 16'hFFFF, 2'b11, e);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL oor_wr_err: ERR=%b expected 1", e);
        end
        read_word(10'd1010, d, v, e);
        checks++;
        if (d !== 16'h0000 || v !== 1'b1 || e !== 1'b1) begin
            errors++;
            $display("FAIL oor_rd: OUT=%h valid=%b err=%b expected 0000 1 1", d, v, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]        op_wr  = 4'b0101;
        logic [3:0]        op_rd  = 4'b1010;
        logic [DATA_W-1:0] op_dat [4] = '{16'h1111, 16'h0000, 16'h5555, 16'h0000};
        logic [1:0]        op_be  [4] = '{2'b11, 2'b00, 2'b10, 2'b00};
        logic [DATA_W-1:0] got [$];
        int errs_seen = 0;
        for (int i = 0; i < 4 + LAT; i++) begin
            WR = (i < 4) ? op_wr[i] : 1'b0;
            RD = (i < 4) ? op_rd[i] : 1'b0;
            ADDR = 10'd7;
            IN = (i < 4) ? op_dat[i] : '0;
            BE = (i < 4) ? op_be[i] : 2'b00;
            step();
            if (OUT_VALID) got.push_back(OUT);
            if (ERR) errs_seen++;
        end
        WR = 1'b0; RD = 1'b0;
        checks++;
        if (got.size() != 2 || errs_seen != 0) begin
            errors++;
            $display("FAIL b2b_count: %0d reads, %0d errs, expected 2 reads 0 errs",
                     got.size(), errs_seen);
        end else begin
            checks++;
            if (got[0] !== 16'h1111 || got[1] !== 16'h5511) begin
                errors++;
                $display("FAIL b2b_data: got %h %h expected 1111 5511", got[0], got[1]);
            end
        end
    endtask

    task automatic test_busy_reject();
        int cyc, vl;
        logic e, v;
        logic [DATA_W-1:0] d;
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        WR = 1'b1; ADDR = 10'd3; IN = 16'hFFFF; BE = 2'b11;
        step();
        WR = 1'b0;
        checks++;
        if (ERR !== 1'b1 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL busy_wr_err: ERR=%b BUSY=%b expected 1 1", ERR, BUSY);
        end
        wait_clear(cyc, vl);
        checks++;
        if (cyc + 1 !== DEPTH) begin
            errors++;
            $display("FAIL busy_clear_len: clear took %0d cycles, expected %0d", cyc + 1, DEPTH);
        end
        read_word(10'd3, d, v, e);
        checks++;
        if (d !== 16'h0000 || v !== 1'b1) begin
            errors++;
            $display("FAIL busy_wr_dropped: OUT=%h valid=%b expected 0000 1", d, v);
        end
        read_word(10'd5, d, v, e);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL reclear_addr5: OUT=%h expected 0000", d);
        end
    endtask

    task automatic test_reset_mid_op();
        int cyc, vl;
        logic e, v;
        logic [DATA_W-1:0] d;
        // Reset with the clear half done and a read burst hammering the port.
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        RD = 1'b1; ADDR = 10'd0;
        repeat (DEPTH / 2) step();
        RST_N = 1'b0;
        #1;
        checks++;
        if (BUSY !== 1'b1 || ERR !== 1'b0 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL midclear_reset: BUSY=%b ERR=%b OUT_VALID=%b expected 1 0 0",
                     BUSY, ERR, OUT_VALID);
        end
        RD = 1'b0;
        step();
        RST_N = 1'b1;
        wait_clear(cyc, vl);
        checks++;
        if (cyc !== DEPTH) begin
            errors++;
            $display("FAIL midclear_rerun: clear took %0d cycles, expected %0d", cyc, DEPTH);
        end
        // Reset while a read of nonzero data is in flight.
        write_word(10'd9, 16'hCAFE, 2'b11, e);
        RD = 1'b1; ADDR = 10'd9;
        step();
        RD = 1'b0;
        RST_N = 1'b0;
        #1;
        checks++;
        if (OUT !== '0 || OUT_VALID !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL inflight_reset: OUT=%h OUT_VALID=%b BUSY=%b expected 0000 0 1",
                     OUT, OUT_VALID, BUSY);
        end
        step();
        RST_N = 1'b1;
        wait_clear(cyc, vl);
        checks++;
        if (cyc !== DEPTH || vl !== 0) begin
            errors++;
            $display("FAIL inflight_discard: clear %0d cycles, %0d valids, expected %0d and 0",
                     cyc, vl, DEPTH);
        end
        read_word(10'd9, d, v, e);
        checks++;
        if (d !== 16'h0000 || v !== 1'b1) begin
            errors++;
            $display("FAIL inflight_cleared: OUT=%h valid=%b expected 0000 1", d, v);
        end
    endtask

    initial begin
        RST_N = 1'b1;
        WR = 1'b0; RD = 1'b0; ADDR = '0; IN = '0; BE = '0;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_collision();
        test_out_of_range();
        test_back_to_back();
        test_busy_reject();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
